// File: rtl/dvp_tx_controller.sv
// DVP transmitter: paces a valid/ready byte stream out as PCLK/VSYNC/HREF/D frames.
// PCLK is divided from clk; every DVP output changes on the PCLK falling edge (tick).
module dvp_tx_controller #(
  parameter int LINE_BYTES   = 8,
  parameter int LINES        = 4,
  parameter int PCLK_DIV     = 4,
  parameter int VSYNC_PCLK   = 2,
  parameter int V_BP_PCLK    = 3,
  parameter int H_BLANK_PCLK = 2,
  parameter int V_FP_PCLK    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start_i,
  input  logic [7:0] px_data_i,
  input  logic       px_valid_i,
  output logic       px_ready_o,
  output logic       dvp_pclk_o,
  output logic       dvp_vsync_o,
  output logic       dvp_href_o,
  output logic [7:0] dvp_d_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       underflow_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_PER = max2(max2(max2(LINE_BYTES, VSYNC_PCLK),
                                     max2(V_BP_PCLK, H_BLANK_PCLK)), V_FP_PCLK);
  localparam int PCNT_W  = $clog2(MAX_PER) + 1;
  localparam int LINE_W  = $clog2(LINES) + 1;
  localparam int DIV_W   = $clog2(PCLK_DIV) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_LINE   = 3'd3,
    S_HBLANK = 3'd4,
    S_VFP    = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [PCNT_W-1:0]   w_pcnt_nxt;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   w_line_nxt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic                r_pclk;
  logic                r_start_pend;
  logic                r_vsync;
  logic                r_href;
  logic [7:0]          r_d;
  logic                r_busy;
  logic                r_done;
  logic                r_underflow;

  logic                w_tick;
  logic                w_last;
  logic                w_slot;
  logic                w_vsync_nxt;
  logic                w_href_nxt;
  logic [7:0]          w_d_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_uf_set;

  // Free-running divider; PCLK is registered from the next count so its falling
  // edge lands on the same clk edge as the tick-driven output updates.
  assign w_tick    = (r_div_cnt == DIV_W'(PCLK_DIV - 1));
  assign w_div_nxt = w_tick ? '0 : r_div_cnt + DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_pclk    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_pclk    <= (w_div_nxt >= DIV_W'(PCLK_DIV / 2));
    end
  end

  // A start is only remembered while idle; one arriving on the launching tick is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_pend <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_tick && r_start_pend) begin
        r_start_pend <= 1'b0;
      end else if (frame_start_i) begin
        r_start_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pcnt  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_line  <= w_line_nxt;
    end
  end

  assign w_last = (r_pcnt == '0);

  // pcnt holds periods remaining minus one, reloaded on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_line_nxt  = r_line;
    if (w_tick) begin
      if (r_state != S_IDLE && !w_last) begin
        w_pcnt_nxt = r_pcnt - PCNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (r_start_pend) begin
            w_state_nxt = S_VSYNC;
            w_pcnt_nxt  = PCNT_W'(VSYNC_PCLK - 1);
          end
        end
        S_VSYNC: begin
          if (w_last) begin
            w_state_nxt = S_VBP;
            w_pcnt_nxt  = PCNT_W'(V_BP_PCLK - 1);
          end
        end
        S_VBP: begin
          if (w_last) begin
            w_state_nxt = S_LINE;
            w_pcnt_nxt  = PCNT_W'(LINE_BYTES - 1);
            w_line_nxt  = '0;
          end
        end
        S_LINE: begin
          if (w_last) begin
            if (r_line == LINE_W'(LINES - 1)) begin
              w_state_nxt = S_VFP;
              w_pcnt_nxt  = PCNT_W'(V_FP_PCLK - 1);
            end else begin
              w_state_nxt = S_HBLANK;
              w_pcnt_nxt  = PCNT_W'(H_BLANK_PCLK - 1);
            end
          end
        end
        S_HBLANK: begin
          if (w_last) begin
            w_state_nxt = S_LINE;
            w_pcnt_nxt  = PCNT_W'(LINE_BYTES - 1);
            w_line_nxt  = r_line + LINE_W'(1);
          end
        end
        S_VFP: begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // A byte slot is any tick that leaves the FSM in LINE.
  always_comb begin
    w_slot      = w_tick && (w_state_nxt == S_LINE);
    w_vsync_nxt = (w_state_nxt == S_VSYNC);
    w_href_nxt  = (w_state_nxt == S_LINE);
    w_d_nxt     = (w_slot && px_valid_i) ? px_data_i : 8'h00;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = w_tick && (r_state == S_VFP) && (w_state_nxt == S_IDLE);
    w_uf_set    = w_slot && !px_valid_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_d         <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_tick) begin
        r_vsync <= w_vsync_nxt;
        r_href  <= w_href_nxt;
        r_d     <= w_d_nxt;
        r_busy  <= w_busy_nxt;
      end
      r_done      <= w_done_nxt;
      r_underflow <= r_underflow | w_uf_set;
    end
  end

  assign px_ready_o   = w_slot;
  assign dvp_pclk_o   = r_pclk;
  assign dvp_vsync_o  = r_vsync;
  assign dvp_href_o   = r_href;
  assign dvp_d_o      = r_d;
  assign busy_o       = r_busy;
  assign frame_done_o = r_done;
  assign underflow_o  = r_underflow;

endmodule

// File: doc/dvp_tx_controller.md
Name: dvp_tx_controller

Overview:
- DVP transmitter, the transmit-side counterpart of the camera RX path: serialises a pixel-byte stream onto a DVP interface (PCLK, VSYNC, HREF, D[7:0]).
- PCLK is derived by dividing the system clock.
- Used as an on-chip camera emulator for loopback tests of the RX controller, and as an outbound DVP port.
- Bytes enter through a valid/ready interface, typically from a pixel FIFO.

Parameters:
- LINE_BYTES, 8, bytes per line (HREF-high PCLK periods per line); >=1
- LINES, 4, lines per frame; >=1
- PCLK_DIV, 4, clk cycles per PCLK period; even, >=2
- VSYNC_PCLK, 2, VSYNC-high width in PCLK periods; >=1
- V_BP_PCLK, 3, PCLK periods from VSYNC fall to first HREF rise; >=1
- H_BLANK_PCLK, 2, HREF-low PCLK periods between lines; >=1
- V_FP_PCLK, 3, PCLK periods after last line before frame end; >=1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start_i  in  1  request one frame; one-clk pulse or level
- px_data_i  in  8  pixel byte
- px_valid_i  in  1  px_data_i valid
- px_ready_o  out  1  byte accepted this cycle when px_valid_i is high
- dvp_pclk_o  out  1  DVP pixel clock
- dvp_vsync_o  out  1  DVP VSYNC, active high
- dvp_href_o  out  1  DVP HREF, active high
- dvp_d_o  out  8  DVP data
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-clk pulse at frame end
- underflow_o  out  1  sticky; set when a byte slot found px_valid_i low

Behaviour:
- Reset (asynchronous, active-low): div_cnt=0; state=IDLE; all outputs 0, including dvp_pclk_o, underflow_o and pending start. A reset mid-frame aborts immediately; VSYNC/HREF drop asynchronously.
- PCLK generator:
  - div_cnt counts 0..PCLK_DIV-1 and wraps; free-running in all states.
  - dvp_pclk_o is registered: 0 while div_cnt < PCLK_DIV/2, else 1.
  - tick = (div_cnt == PCLK_DIV-1).
  - All DVP outputs update only in the clk edge where tick is high, i.e. coincident with the PCLK falling edge. Data is stable for the whole high phase, and the receiver samples on the PCLK rising edge.
- Start:
  - frame_start_i high in any clk while IDLE sets start_pend.
  - frame_start_i while busy_o=1 is ignored; it is not queued.
- FSM states: IDLE, VSYNC, VBP, LINE, HBLANK, VFP.
  - All transitions happen on tick. A period counter pcnt reloads on every state entry.
  - IDLE -> VSYNC when start_pend on tick; clears start_pend; sets busy_o and dvp_vsync_o.
  - VSYNC: VSYNC_PCLK periods, then -> VBP; dvp_vsync_o=0.
  - VBP: V_BP_PCLK periods, then -> LINE; line counter=0.
  - LINE: LINE_BYTES periods, dvp_href_o=1. Then -> HBLANK if line < LINES-1; else -> VFP. dvp_href_o and dvp_d_o go to 0 on exit.
  - HBLANK: H_BLANK_PCLK periods, then -> LINE; line counter +1.
  - VFP: V_FP_PCLK periods, then -> IDLE. On that tick: busy_o=0 and frame_done_o=1 for one clk.
- Byte slot and handshake:
  - Each tick that places a byte on the bus is a byte slot: entry to LINE, plus every subsequent tick while remaining in LINE.
  - px_ready_o = slot tick (combinational, one-clk pulse per byte); never high outside slots.
  - In a slot: if px_valid_i=1, dvp_d_o <= px_data_i (byte consumed). If px_valid_i=0, dvp_d_o <= 8'h00, underflow_o <= 1, and no byte is consumed; the frame continues with its timing unchanged.
  - underflow_o clears only on reset.
- Frame totals: bytes consumed per frame = LINE_BYTES*LINES exactly when no underflow occurs. Frame length in PCLK periods = VSYNC_PCLK + V_BP_PCLK + LINES*LINE_BYTES + (LINES-1)*H_BLANK_PCLK + V_FP_PCLK.
- Counter widths: $clog2 of the largest count, +1. No wrap is possible within a frame.

Test Plan:
- Reset values: assert rst_n=0 mid-LINE -> all outputs 0 immediately. After release, dvp_pclk_o toggles with period PCLK_DIV clk (4) and 50% duty; vsync and href stay 0.
- Nominal frame with defaults and always-valid incrementing bytes 0x00.. -> VSYNC high 2 PCLK, 3 PCLK gap, 4 HREF pulses of 8 PCLK each separated by 2 PCLK, 32 bytes 0x00..0x1F sampled on PCLK rise, then frame_done_o after 3 PCLK; busy_o is 0 afterwards; underflow_o=0.
- Underflow: drop px_valid_i for slot 5 -> dvp_d_o=0x00 at slot 5; underflow_o=1 and stays 1; the remaining bytes shift by one; HREF timing is unchanged; 31 bytes consumed.
- Start during busy: pulse frame_start_i mid-frame -> no second frame. A pulse in IDLE -> VSYNC rises on the next tick.
- Back-to-back: hold frame_start_i high -> next VSYNC rises on the first tick after frame_done_o; ready pulse count = 32 per frame.
- PCLK_DIV=2, LINE_BYTES=1, LINES=1 -> one HREF period of 2 clk; px_ready_o pulses exactly once per frame.
